alu_pipe: RTL

- Parametrised next-generation ALU for the system datapath; takes operands from the register-file/control path and returns results to the SYS_CTRL/UART response path.
- Uses an in_valid/in_ready input handshake and a one-cycle out_valid result pulse.
- Adds an iterative multi-cycle restoring divider with remainder, carry and zero flags, a divide-by-zero flag, and variable shift amounts.
- Single-cycle ops have fixed 1-cycle latency; division takes DATA_WIDTH+1 cycles.

---
 rtl/alu_pipe.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// Unsigned ALU with a valid/ready request port, one-cycle result pulse and an
// iterative restoring divider that keeps the unit busy for DATA_WIDTH+1 cycles.
module alu_pipe #(
    parameter int DATA_WIDTH  = 8,
    parameter int SHAMT_WIDTH = 3
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     A,
    input  logic [DATA_WIDTH-1:0]     B,
    input  logic [3:0]                ALU_FUN,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [2*DATA_WIDTH-1:0]   alu_out,
    output logic                      out_valid,
    output logic                      carry_flag,
    output logic                      zero_flag,
    output logic                      div_by_zero
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000, OP_SUB  = 4'b0001, OP_MUL  = 4'b0010, OP_DIV  = 4'b0011,
        OP_AND  = 4'b0100, OP_OR   = 4'b0101, OP_NAND = 4'b0110, OP_NOR  = 4'b0111,
        OP_XOR  = 4'b1000, OP_XNOR = 4'b1001, OP_EQ   = 4'b1010, OP_GT   = 4'b1011,
        OP_LT   = 4'b1100, OP_SHR  = 4'b1101, OP_SHL  = 4'b1110, OP_ASR  = 4'b1111
    } op_t;

    typedef enum logic {
        IDLE,
        DIV
    } state_t;

    state_t          state;
    logic [W-1:0]    rem;
    logic [W-1:0]    quo;
    logic [W-1:0]    divisor;
    logic [CW-1:0]   count;

    logic [2*W-1:0]  res;
    logic            res_carry;
    logic [W:0]      sum;
    logic [W-1:0]    diff;
    logic [2*W-1:0]  prod;
    logic [2*W-1:0]  shl;
    logic [W-1:0]    asr;
    logic [SHAMT_WIDTH-1:0] shamt;

    logic [W:0]      rem_sh;
    logic [W:0]      rem_diff;
    logic            step_ge;
    logic [W-1:0]    rem_next;

    assign in_ready = (state == IDLE);

    assign shamt = B[SHAMT_WIDTH-1:0];
    assign sum   = {1'b0, A} + {1'b0, B};
    assign diff  = A - B;
    assign prod  = {{W{1'b0}}, A} * {{W{1'b0}}, B};
    assign shl   = {{W{1'b0}}, A} << shamt;
    assign asr   = W'($signed(A) >>> shamt);

    // One restoring step: shift the next dividend bit into the partial
    // remainder, keep the trial difference only when it did not borrow.
    assign rem_sh   = {rem, quo[W-1]};
    assign rem_diff = rem_sh - {1'b0, divisor};
    assign step_ge  = (rem_sh >= {1'b0, divisor});
    assign rem_next = step_ge ? rem_diff[W-1:0] : rem_sh[W-1:0];

    // NOTE: every output of a combinational block gets a default first, so no
    // opcode path can leave a value unassigned and infer a latch.
    always_comb begin
        res       = '0;
        res_carry = 1'b0;
        case (ALU_FUN)
            OP_ADD: begin
                res       = {{(W-1){1'b0}}, sum};
                res_carry = sum[W];
            end
            OP_SUB: begin
                res       = {{W{1'b0}}, diff};
                res_carry = (A < B);
            end
            OP_MUL:  res = prod;
            OP_AND:  res = {{W{1'b0}}, A & B};
            OP_OR:   res = {{W{1'b0}}, A | B};
            OP_NAND: res = {{W{1'b0}}, ~(A & B)};
            OP_NOR:  res = {{W{1'b0}}, ~(A | B)};
            OP_XOR:  res = {{W{1'b0}}, A ^ B};
            OP_XNOR: res = {{W{1'b0}}, ~(A ^ B)};
            OP_EQ:   res = (A == B) ? (2*W)'(1) : '0;
            OP_GT:   res = (A > B)  ? (2*W)'(2) : '0;
            OP_LT:   res = (A < B)  ? (2*W)'(3) : '0;
            OP_SHR:  res = {{W{1'b0}}, A >> shamt};
            OP_SHL:  res = shl;
            OP_ASR:  res = {{W{1'b0}}, asr};
            default: res = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            alu_out     <= '0;
            out_valid   <= 1'b0;
            carry_flag  <= 1'b0;
            zero_flag   <= 1'b0;
            div_by_zero <= 1'b0;
            rem         <= '0;
            quo         <= '0;
            divisor     <= '0;
            count       <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (ALU_FUN == OP_DIV) begin
                            if (B == '0) begin
                                alu_out     <= {A, {W{1'b1}}};
                                out_valid   <= 1'b1;
                                carry_flag  <= 1'b0;
                                zero_flag   <= 1'b0;
                                div_by_zero <= 1'b1;
                            end else begin
                                state   <= DIV;
                                rem     <= '0;
                                quo     <= A;
                                divisor <= B;
                                count   <= CW'(W);
                            end
                        end else begin
                            alu_out     <= res;
                            out_valid   <= 1'b1;
                            carry_flag  <= res_carry;
                            zero_flag   <= (res == '0);
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                DIV: begin
                    if (count == '0) begin
                        state       <= IDLE;
                        alu_out     <= {rem, quo};
                        out_valid   <= 1'b1;
                        carry_flag  <= 1'b0;
                        zero_flag   <= ({rem, quo} == '0);
                        div_by_zero <= 1'b0;
                    end else begin
                        rem   <= rem_next;
                        quo   <= {quo[W-2:0], step_ge};
                        count <= count - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
